load_store_unit: RTL and testbench

- Memory-side responder for the load/store control signals the main decoder issues (MemRead/MemWrite plus funct3).
- Turns a single-cycle pipeline load/store request into a word-aligned req/ack bus transaction: byte enables, store-data lane replication, load-data extraction with sign/zero extension.
- Stalls the pipeline until the bus completes or times out.
- Sits between the EX/MEM stage and the data-memory bus.

---
 rtl/load_store_unit.sv | 147 ++++++++++++++
 tb/tb_load_store_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store responder: turns a single-cycle MemRead/MemWrite request into a
// word-aligned req/ack bus transaction with lane steering and a bounded wait.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_MemRead,
  input  logic                  i_MemWrite,
  input  logic [2:0]            i_Funct3,
  input  logic [ADDR_WIDTH-1:0] i_Addr,
  input  logic [31:0]           i_WData,
  output logic [31:0]           o_RData,
  output logic                  o_Stall,
  output logic                  o_Done,
  output logic                  o_Error,
  output logic                  o_BusReq,
  output logic                  o_BusWe,
  output logic [ADDR_WIDTH-1:0] o_BusAddr,
  output logic [3:0]            o_BusBe,
  output logic [31:0]           o_BusWData,
  input  logic                  i_BusAck,
  input  logic [31:0]           i_BusRData
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            lane_q;
  logic [2:0]            funct3_q;
  logic                  we_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;
  logic                  abort_q;

  logic        req, legal, f3_ok, align_ok;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] load_data;
  logic [31:0] shifted;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    f3_ok    = 1'b0;
    align_ok = 1'b0;
    case (i_Funct3)
      3'b000: begin f3_ok = 1'b1;      align_ok = 1'b1;              end
      3'b001: begin f3_ok = 1'b1;      align_ok = ~i_Addr[0];        end
      3'b010: begin f3_ok = 1'b1;      align_ok = (i_Addr[1:0] == 2'b00); end
      3'b100: begin f3_ok = i_MemRead; align_ok = 1'b1;              end
      3'b101: begin f3_ok = i_MemRead; align_ok = ~i_Addr[0];        end
      default: begin f3_ok = 1'b0;     align_ok = 1'b0;              end
    endcase
    req   = i_MemRead | i_MemWrite;
    legal = (i_MemRead ^ i_MemWrite) & f3_ok & align_ok;

    case (i_Funct3[1:0])
      2'b00: begin
        be_n    = 4'b0001 << i_Addr[1:0];
        wdata_n = {4{i_WData[7:0]}};
      end
      2'b01: begin
        be_n    = 4'b0011 << {i_Addr[1], 1'b0};
        wdata_n = {2{i_WData[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = i_WData;
      end
    endcase
  end

  // Load lane is selected from the captured address, not the live input.
  always_comb begin
    shifted = i_BusRData >> {lane_q, 3'b000};
    rbyte   = shifted[7:0];
    rhalf   = lane_q[1] ? i_BusRData[31:16] : i_BusRData[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{rbyte[7]}}, rbyte};
      3'b100:  load_data = {24'h0, rbyte};
      3'b001:  load_data = {{16{rhalf[15]}}, rhalf};
      3'b101:  load_data = {16'h0, rhalf};
      default: load_data = i_BusRData;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      lane_q   <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      abort_q  <= 1'b0;
      o_RData  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && legal) begin
            addr_q   <= {i_Addr[ADDR_WIDTH-1:2], 2'b00};
            lane_q   <= i_Addr[1:0];
            funct3_q <= i_Funct3;
            we_q     <= i_MemWrite;
            be_q     <= be_n;
            wdata_q  <= wdata_n;
            cnt      <= '0;
            abort_q  <= 1'b0;
            state    <= REQ;
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          // An ack arriving on the final allowed cycle wins over the abort.
          if (i_BusAck) begin
            if (!we_q) o_RData <= load_data;
            state <= DONE;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            abort_q <= 1'b1;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_BusReq   = (state == REQ);
    o_BusWe    = (state == REQ) & we_q;
    o_BusAddr  = addr_q;
    o_BusBe    = (state == REQ) ? be_q : 4'b0000;
    o_BusWData = wdata_q;
    o_Stall    = (state == REQ) | ((state == IDLE) & req & legal);
    o_Done     = (state == DONE);
    o_Error    = ((state == DONE) & abort_q) | ((state == IDLE) & req & ~legal);
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus timeout and reset sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, done, error;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] hold_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .i_CLK(clk), .i_RST(rst),
    .i_MemRead(mem_read), .i_MemWrite(mem_write), .i_Funct3(funct3),
    .i_Addr(addr), .i_WData(wdata),
    .o_RData(rdata), .o_Stall(stall), .o_Done(done), .o_Error(error),
    .o_BusReq(bus_req), .o_BusWe(bus_we), .o_BusAddr(bus_addr),
    .o_BusBe(bus_be), .o_BusWData(bus_wdata),
    .i_BusAck(bus_ack), .i_BusRData(bus_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brdata;
    int          dly;
    logic        legal;
    logic [3:0]  be;
    logic [31:0] bwd;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    funct3    = 3'b000;
    addr      = '0;
    wdata     = '0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int stalls;
    @(negedge clk);
    mem_read = v.rd; mem_write = v.wr; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    #1;
    if (!v.legal) begin
      chk($sformatf("v%0d_err_pulse", idx), {31'b0, error}, 32'd1);
      chk($sformatf("v%0d_ill_stall", idx), {31'b0, stall}, 32'd0);
      @(negedge clk);
      idle_inputs();
      #1;
      chk($sformatf("v%0d_ill_busreq", idx), {31'b0, bus_req}, 32'd0);
      chk($sformatf("v%0d_ill_err_gone", idx), {31'b0, error}, 32'd0);
      chk($sformatf("v%0d_ill_rdata", idx), rdata, hold_rdata);
      return;
    end
    chk($sformatf("v%0d_req_err", idx), {31'b0, error}, 32'd0);
    stalls = stall ? 1 : 0;
    for (int k = 1; k <= v.dly; k++) begin
      @(negedge clk);
      if (k == v.dly) begin
        bus_ack   = 1'b1;
        bus_rdata = v.brdata;
      end
      #1;
      if (stall) stalls++;
      chk($sformatf("v%0d_busreq_c%0d", idx, k), {31'b0, bus_req}, 32'd1);
      chk($sformatf("v%0d_buswe", idx), {31'b0, bus_we}, {31'b0, v.wr});
      chk($sformatf("v%0d_busaddr", idx), bus_addr, {v.addr[31:2], 2'b00});
      chk($sformatf("v%0d_busbe", idx), {28'b0, bus_be}, {28'b0, v.be});
      if (v.wr) chk($sformatf("v%0d_buswdata", idx), bus_wdata, v.bwd);
    end
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = 32'h5A5A_5A5A;
    #1;
    chk($sformatf("v%0d_done", idx), {31'b0, done}, 32'd1);
    chk($sformatf("v%0d_done_err", idx), {31'b0, error}, 32'd0);
    chk($sformatf("v%0d_done_stall", idx), {31'b0, stall}, 32'd0);
    chk($sformatf("v%0d_done_busreq", idx), {31'b0, bus_req}, 32'd0);
    if (v.rd) hold_rdata = v.rdata;
    chk($sformatf("v%0d_rdata", idx), rdata, hold_rdata);
    chk($sformatf("v%0d_stall_cycles", idx), stalls, v.dly + 1);
    idle_inputs();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus_ack = 1'b0;
    bus_rdata = '0;
    idle_inputs();
    hold_rdata = '0;

    //           rd    wr    f3      addr          wdata         brdata        dly legal be       bwd           rdata
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 2, 1'b1, 4'b1000, 32'h0,        32'hFFFF_FF80};
    vecs[1]  = '{1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'hBEEF_0000, 1, 1'b1, 4'b1100, 32'h0,        32'h0000_BEEF};
    vecs[2]  = '{1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0,        32'hBEEF_0000, 1, 1'b1, 4'b1100, 32'h0,        32'hFFFF_BEEF};
    vecs[3]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0005, 32'h1234_56A5, 32'h0,        1, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0006, 32'h1234_56A5, 32'h0,        3, 1'b1, 4'b1100, 32'h56A5_56A5, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1, 1'b1, 4'b1111, 32'h0,        32'hDEAD_BEEF};
    vecs[6]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0,        32'h0000_8000, 1, 1'b1, 4'b0010, 32'h0,        32'h0000_0080};
    vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0002, 32'h0,        32'h0,        0, 1'b0, 4'b0000, 32'h0,        32'h0};
    vecs[8]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0001, 32'h0,        32'h0,        0, 1'b0, 4'b0000, 32'h0,        32'h0};
    vecs[9]  = '{1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 1'b0, 4'b0000, 32'h0,        32'h0};
    vecs[10] = '{1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0,        32'h0,        0, 1'b0, 4'b0000, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,        0, 1'b0, 4'b0000, 32'h0,        32'h0};
    vecs[12] = '{1'b0, 1'b1, 3'b010, 32'h0000_0008, 32'hCAFE_F00D, 32'h0,        16, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 3'b000, 32'h0000_0000, 32'h0,        32'h0000_007F, 1, 1'b1, 4'b0001, 32'h0,        32'h0000_007F};
    vecs[14] = '{1'b1, 1'b0, 3'b001, 32'h0000_0000, 32'h0,        32'h1234_8001, 1, 1'b1, 4'b0011, 32'h0,        32'hFFFF_8001};

    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busreq", {31'b0, bus_req}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    chk("rst_busbe", {28'b0, bus_be}, 32'd0);
    chk("rst_busaddr", bus_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Timeout: no ack, request must stay up for exactly TIMEOUT_CYCLES cycles.
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0040;
    #1;
    chk("to_req_stall", {31'b0, stall}, 32'd1);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (!bus_req) break;
      n++;
    end
    chk("to_busreq_cycles", n, 16);
    chk("to_done", {31'b0, done}, 32'd1);
    chk("to_error", {31'b0, error}, 32'd1);
    chk("to_stall", {31'b0, stall}, 32'd0);
    chk("to_rdata_hold", rdata, hold_rdata);
    idle_inputs();
    @(negedge clk);
    #1;
    chk("to_err_gone", {31'b0, error}, 32'd0);

    // Reset in the middle of a REQ; the following ack must be ignored.
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0080;
    @(negedge clk);
    #1;
    chk("mr_busreq_before", {31'b0, bus_req}, 32'd1);
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("mr_busreq", {31'b0, bus_req}, 32'd0);
    chk("mr_stall", {31'b0, stall}, 32'd0);
    chk("mr_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 32'h1111_2222;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("mr_late_ack_done", {31'b0, done}, 32'd0);
    chk("mr_late_ack_busreq", {31'b0, bus_req}, 32'd0);
    chk("mr_late_ack_rdata", rdata, 32'h0);
    chk("mr_late_ack_error", {31'b0, error}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
